// File: rtl/ssd_pkg.sv
// Shared constants and segment encoding for the multiplexed seven-segment display path.
// Latency: none (pure constants and combinational helper).
// Backpressure: not applicable.
package ssd_pkg;

  // Widest display this driver family supports; anode constants are sized to it.
  localparam int MAX_DIGITS = 8;

  // Active-low segment bus with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low anode bus with every digit deselected; slice to the digit count in use.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1, flags the last cycle of each slot and the guard band at its start.
// Latency: tick and guard_active are decoded from the counter flop, valid in the same cycle.
// Backpressure: none; free-running from reset release.
module ssd_tick_gen #(
  parameter int TICK_DIV = 200000,
  parameter int GUARD    = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick,
  output logic guard_active
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Guard band covers the first GUARD cycles of each slot; zero means no guard at all.
  if (GUARD == 0) begin : g_no_guard
    assign guard_active = 1'b0;
  end else begin : g_guard
    assign guard_active = (cnt_q < CW'(GUARD));
  end

  // Next prescaler value: wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// N-digit multiplexed seven-segment driver with frame-synchronous shadow, guard band, digit mask, LZ blanking.
// Latency: anodes/cathodes/frame_done registered, 1 cycle after prescaler/index/shadow state.
// Backpressure: none; number_valid is a fire-and-forget strobe (last in a frame wins). Optional: SSD_BLINK_EN.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 200000,
  parameter int GUARD       = 2,
  parameter int BLINK_SLOTS = 250
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic                  number_valid,
  input  logic [DIGITS-1:0]     digit_enable,
  input  logic                  lz_blank_en,
`ifdef SSD_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            cathodes,
  output logic                  frame_done
);

  localparam int KW = $clog2(DIGITS);
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  logic tick;
  logic guard_active;
  logic boundary;

  logic [KW-1:0]       k_q, k_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]          cathodes_q, cathodes_d;
  logic                frame_done_q, frame_done_d;

  // Slot decode intermediates.
  logic [DIGITS-1:0] lz_mask;
  logic              lz_run;
  logic [3:0]        nib;
  logic [DIGITS-1:0] an_sel;
  logic              digit_on;
  logic              blank;

  ssd_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .GUARD    (GUARD)
  ) u_tick_gen (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick         (tick),
    .guard_active (guard_active)
  );

  // The frame ends on the tick that closes the rightmost digit's slot.
  assign boundary = tick && (k_q == K_LAST);

`ifdef SSD_BLINK_EN
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Count slot ticks; flip the blink phase every BLINK_SLOTS of them.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_SLOTS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers; phase starts in the visible half.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = (BLINK_SLOTS > 0);
`endif

  // Scan index advances once per slot and wraps after the rightmost digit.
  always_comb begin
    k_d = k_q;
    if (tick) begin
      k_d = boundary ? '0 : k_q + 1'b1;
    end
  end

  // Capture: strobes land in pending; shadow only changes at the frame boundary,
  // taking a coincident strobe directly so it is not delayed a whole frame.
  always_comb begin
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    frame_done_d = boundary;
    if (number_valid) begin
      pending_d = number;
    end
    if (boundary) begin
      shadow_d = number_valid ? number : pending_q;
    end
  end

  // Leading-zero mask indexed by scan position: set while every digit from the left is zero.
  // The rightmost digit is never masked so a zero value still shows "0".
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lz_run = lz_run && (shadow_q[4*(DIGITS-i)-1 -: 4] == 4'h0);
      if (i != DIGITS - 1) begin
        lz_mask[i] = lz_run;
      end
    end
  end

  // Select the current digit's nibble and anode, then apply every blanking source.
  always_comb begin
    nib      = 4'h0;
    an_sel   = ANODE_OFF[DIGITS-1:0];
    digit_on = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k_q == KW'(i)) begin
        nib                 = shadow_q[4*(DIGITS-i)-1 -: 4];
        an_sel[DIGITS-1-i]  = 1'b0;
        digit_on            = digit_enable[DIGITS-1-i] && !(lz_blank_en && lz_mask[i]);
`ifdef SSD_BLINK_EN
        digit_on            = digit_on && !(blink_phase_q && blink_mask[DIGITS-1-i]);
`endif
      end
    end
    blank      = guard_active || !digit_on;
    anodes_d   = blank ? ANODE_OFF[DIGITS-1:0] : an_sel;
    cathodes_d = blank ? SEG_BLANK : hex_to_seg(nib);
  end

  // Scan state and registered pin drivers; reset darkens the display immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q          <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      anodes_q     <= ANODE_OFF[DIGITS-1:0];
      cathodes_q   <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      k_q          <= k_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes     = anodes_q;
  assign cathodes   = cathodes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: per-cycle expectations from a cycle-arithmetic display model.
// Latency: expectation for state cycle t is compared one clock later.
// Backpressure: none; the monitor pops one expectation per clock.
module tb_ssd_scan_mux;

  localparam int D  = 4;
  localparam int TD = 4;
  localparam int GD = 1;
  localparam int BS = 8;
  localparam int F  = D * TD;

  typedef struct packed {
    logic [D-1:0] an;
    logic [6:0]   seg;
    logic         fd;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   number = 16'h0;
  logic          number_valid = 1'b0;
  logic [D-1:0]  digit_enable = 4'hF;
  logic          lz_blank_en = 1'b0;
`ifdef SSD_BLINK_EN
  logic [D-1:0]  blink_mask = 4'h0;
`endif
  logic [D-1:0]  anodes;
  logic [6:0]    cathodes;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t         exp_q[$];
  int unsigned  strobe_cyc[$];
  logic [15:0]  strobe_val[$];
  int unsigned  t = 0;
  bit           mon_en = 1'b0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  ssd_scan_mux #(
    .DIGITS      (D),
    .TICK_DIV    (TD),
    .GUARD       (GD),
    .BLINK_SLOTS (BS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .number       (number),
    .number_valid (number_valid),
    .digit_enable (digit_enable),
    .lz_blank_en  (lz_blank_en),
`ifdef SSD_BLINK_EN
    .blink_mask   (blink_mask),
`endif
    .anodes       (anodes),
    .cathodes     (cathodes),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d, time %0t)", name, act, req, t, $time);
    end
  endtask

  // Displayed value during frame f: the most recent strobe issued before that frame began.
  function automatic logic [15:0] shadow_for_frame(input int unsigned f);
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < strobe_cyc.size(); i++) begin
      if (strobe_cyc[i] < f * F) v = strobe_val[i];
    end
    return v;
  endfunction

  // Expected pin state after the clock that ends state cycle t, given the inputs applied now.
  task automatic push_expect();
    exp_t        e;
    int unsigned p, k, f, pos;
    logic [15:0] sh;
    logic [3:0]  nib;
    logic        blank;
    e.an  = '1;
    e.seg = 7'h7F;
    e.fd  = 1'b0;
    if (reset_n) begin
      p     = t % TD;
      k     = (t / TD) % D;
      f     = t / F;
      pos   = D - 1 - k;
      sh    = shadow_for_frame(f);
      nib   = 4'(sh >> (4 * pos));
      blank = (p < GD) || !digit_enable[pos] ||
              (lz_blank_en && (k != D - 1) && ((sh >> (4 * pos)) == 16'h0));
`ifdef SSD_BLINK_EN
      blank = blank || ((((t / TD) / BS) % 2 == 1) && blink_mask[pos]);
`endif
      if (!blank) begin
        e.an  = ~(4'b0001 << pos);
        e.seg = seg_tab[nib];
      end
      e.fd = (t % F == F - 1);
      if (number_valid) begin
        strobe_cyc.push_back(t);
        strobe_val.push_back(number);
      end
      t++;
    end
    exp_q.push_back(e);
  endtask

  // Called while positioned at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input logic sv, input logic [15:0] val);
    number_valid = sv;
    number       = val;
    push_expect();
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset_n      = 1'b0;
    number_valid = 1'b0;
    #1;
    chk("async_rst_anodes", 32'(anodes), 32'hF);
    chk("async_rst_cathodes", 32'(cathodes), 32'h7F);
    chk("async_rst_frame_done", 32'(frame_done), 32'h0);
    push_expect();
    mon_en = 1'b1;
    @(negedge clock);
    repeat (n - 1) begin
      push_expect();
      @(negedge clock);
    end
    reset_n = 1'b1;
    t = 0;
    strobe_cyc.delete();
    strobe_val.delete();
    push_expect();
    @(negedge clock);
  endtask

  task automatic run_to(input int unsigned ph);
    while (t % F != ph) step(1'b0, 16'h0);
  endtask

  // Monitor: one expectation per clock, compared shortly after the edge.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got no expectation, required one at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("anodes", 32'(anodes), 32'(e.an));
        chk("cathodes", 32'(cathodes), 32'(e.seg));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  // Stimulus.
  initial begin
    @(negedge clock);
    do_reset(3);

    // Value strobed mid-frame appears only from the next frame on.
    run_to(5);
    step(1'b1, 16'h12AF);
    repeat (3 * F) step(1'b0, 16'h0);

    // Leading-zero blanking.
    lz_blank_en = 1'b1;
    run_to(2);
    step(1'b1, 16'h0030);
    repeat (2 * F) step(1'b0, 16'h0);
    step(1'b1, 16'h0000);
    repeat (2 * F) step(1'b0, 16'h0);
    lz_blank_en = 1'b0;

    // Strobe on the boundary tick bypasses pending; one cycle later waits a frame.
    run_to(F - 1);
    step(1'b1, 16'hBEEF);
    step(1'b1, 16'hC0DE);
    repeat (3 * F) step(1'b0, 16'h0);

    // Digit mask, then reset in the middle of slot 2.
    digit_enable = 4'b0101;
    repeat (2 * F) step(1'b0, 16'h0);
    digit_enable = 4'hF;
    run_to(9);
    do_reset(2);
    repeat (F) step(1'b0, 16'h0);

`ifdef SSD_BLINK_EN
    blink_mask = 4'b0001;
    step(1'b1, 16'h5678);
    repeat (40 * TD) step(1'b0, 16'h0);
    blink_mask = 4'h0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) digit_enable = 4'($urandom);
      if ($urandom_range(0, 59) == 0) lz_blank_en = ~lz_blank_en;
`ifdef SSD_BLINK_EN
      if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
`endif
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1 + int'($urandom_range(0, 2)));
      end else if ($urandom_range(0, 19) == 0) begin
        step(1'b1, 16'($urandom) >> (4 * $urandom_range(0, 4)));
      end else begin
        step(1'b0, 16'h0);
      end
    end

    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
